con_uart_tx: RTL and testbench
==============================

CON_UART_TX -- requirements
Module: con_uart_tx

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 868: clocks per UART bit period (100 MHz / 115200 baud); legal values are 4 or more.
REQ-002 SHALL have parameter CMD_ADDR, default 10'h200: datamem word address of the command/status mailbox.
REQ-003 SHALL have port clk  input  1  system clock; all logic is on the rising edge.
REQ-004 SHALL have port rst  input  1  reset; one clock domain; reset is synchronous and active-high.
REQ-005 SHALL have port con_out  input  32  read data from the datamem controller port.
REQ-006 SHALL have port con_addr  output  10  word address to the datamem controller port.
REQ-007 SHALL have port con_write  output  4  byte write enables to the datamem controller port.
REQ-008 SHALL have port con_in  output  32  write data to the datamem controller port.
REQ-009 SHALL have port tx  output  1  UART serial line, 8N1, idle high.
REQ-010 SHALL have port busy  output  1  high from command acceptance until the status writeback completes.

Function
REQ-011 SHALL treat datamem reads as 1-clock latency: con_out is valid at the first rising edge after the edge at which con_addr is presented.
REQ-012 SHALL decode the command word as: bit31 GO, bits[25:16] start word address, bits[11:0] byte count; all other bits are ignored.
REQ-013 SHALL implement states IDLE, POLL, FETCH, FETCH_WAIT, START, DATA, STOP, WB.
REQ-014 IDLE SHALL drive con_addr=CMD_ADDR and go to POLL; POLL SHALL sample con_out and go to FETCH if GO=1, to WB if GO=1 and count=0, and to IDLE otherwise.
REQ-015 On GO=1, SHALL latch base address and count into internal registers and assert busy from that edge on.
REQ-016 FETCH SHALL drive con_addr=current word address; FETCH_WAIT SHALL latch con_out into a 32-bit word buffer and go to START.
REQ-017 SHALL send bytes little-endian: byte k of the message is buffer bits [8*(k mod 4)+7 : 8*(k mod 4)].
REQ-018 Each frame SHALL be: start bit (0), then 8 data bits LSB first, then stop bit (1), each bit held for exactly CLKS_PER_BIT clocks.
REQ-019 After STOP, SHALL go to WB if all bytes are sent, to FETCH if the next byte index is a multiple of 4 (giving exactly 2 extra idle-high clocks), and to START otherwise (giving 0 gap clocks).
REQ-020 The word address SHALL increment by 1 per fetch and wrap from 10'h3FF to 10'h000.
REQ-021 WB SHALL drive con_addr=CMD_ADDR, con_write=4'b1111 and con_in={1'b0, 1'b1, 4'b0, base[9:0], 4'b0, count[11:0]} for exactly one clock, then deassert busy and return to IDLE.
REQ-022 con_write SHALL be 4'b0000 in every state except WB.
REQ-023 Core writes to the mailbox while busy SHALL be ignored until the writeback; the writeback overwrites the mailbox.
REQ-024 A count of 0 SHALL produce no frame; tx stays high, and the writeback still occurs.
REQ-025 tx SHALL be registered and glitch-free, and SHALL be 1 in every state except the START and DATA bit periods.

Reset
REQ-026 With rst=1 at a rising edge, the state SHALL become IDLE with tx=1, busy=0, con_write=4'b0000, con_addr=CMD_ADDR and con_in=0, and the bit, byte and baud counters cleared.
REQ-027 A reset mid-frame SHALL abort the transfer without writeback; tx SHALL return to 1 at the next edge, and the mailbox SHALL keep GO=1 so the command restarts after reset.

Verification (CLKS_PER_BIT=4, CMD_ADDR=10'h200)
REQ-028 Reset: hold rst for 3 clocks -> tx=1, busy=0, con_write=0 on every cycle.
REQ-029 mem[0x200]=32'h8001_0003 and mem[0x001]=32'h4433_2211 -> tx carries bytes 0x11, 0x22, 0x33 (40 clocks each, no gaps); then mem[0x200]=32'h4001_0003 and busy falls.
REQ-030 mem[0x200]=32'h8005_0000 -> no start bit; mem[0x200]=32'h4005_0000 within 4 clocks of the poll.
REQ-031 mem[0x200]=32'h83FF_0005, mem[0x3FF]=32'hDDCC_BBAA and mem[0x000]=32'h0000_00EE -> bytes AA, BB, CC, DD, EE; exactly 2 idle-high clocks between DD and EE; address wraps to 0x000.
REQ-032 Assert rst during the 4th data bit of the first byte in the REQ-029 setup -> tx=1 on the next edge; no write occurs; after release the full message retransmits.
REQ-033 mem[0x200]=32'h0001_0003 (GO=0) -> continuous polling, tx stays high, con_write is never nonzero over 200 clocks.

Source files
------------

// File: rtl/con_uart_tx.sv
// UART transmitter fed from a datamem mailbox.
// Polls a command word, streams bytes 8N1, writes status back.
module con_uart_tx #(
    parameter int         CLKS_PER_BIT = 868,
    parameter logic [9:0] CMD_ADDR     = 10'h200
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] con_out,
    output logic [9:0]  con_addr,
    output logic [3:0]  con_write,
    output logic [31:0] con_in,
    output logic        tx,
    output logic        busy
);

    localparam int BW = $clog2(CLKS_PER_BIT);
    localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);

    localparam logic [2:0] IDLE       = 3'd0;
    localparam logic [2:0] POLL       = 3'd1;
    localparam logic [2:0] FETCH      = 3'd2;
    localparam logic [2:0] FETCH_WAIT = 3'd3;
    localparam logic [2:0] START      = 3'd4;
    localparam logic [2:0] DATA       = 3'd5;
    localparam logic [2:0] STOP       = 3'd6;
    localparam logic [2:0] WB         = 3'd7;

    logic [2:0]    state;
    logic [BW-1:0] baud;
    logic [2:0]    bit_cnt;
    logic [11:0]   byte_idx;
    logic [11:0]   count;
    logic [9:0]    base;
    logic [9:0]    word_addr;
    logic [31:0]   wbuf;
    logic [7:0]    shreg;
    logic [11:0]   next_idx;
    logic          unused_cmd_bits;

    assign unused_cmd_bits = ^{con_out[30:26], con_out[15:12]};
    assign next_idx = byte_idx + 12'd1;

    function automatic logic [7:0] pick(input logic [31:0] w,
                                        input logic [1:0]  k);
        logic [7:0] b;
        case (k)
            2'd0:    b = w[7:0];
            2'd1:    b = w[15:8];
            2'd2:    b = w[23:16];
            default: b = w[31:24];
        endcase
        return b;
    endfunction

    // Mailbox port: address the word being fetched, else the mailbox.
    always_comb begin
        con_addr  = CMD_ADDR;
        con_write = 4'b0000;
        con_in    = 32'd0;
        if (state == FETCH) begin
            con_addr = word_addr;
        end
        if (state == WB) begin
            con_write = 4'b1111;
            con_in    = {1'b0, 1'b1, 4'b0, base, 4'b0, count};
        end
    end

    // Control FSM with registered serial output and bit timing.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            tx        <= 1'b1;
            busy      <= 1'b0;
            baud      <= '0;
            bit_cnt   <= 3'd0;
            byte_idx  <= 12'd0;
            count     <= 12'd0;
            base      <= 10'd0;
            word_addr <= 10'd0;
            wbuf      <= 32'd0;
            shreg     <= 8'd0;
        end else begin
            case (state)
                IDLE: begin
                    tx    <= 1'b1;
                    state <= POLL;
                end
                POLL: begin
                    if (con_out[31]) begin
                        base      <= con_out[25:16];
                        word_addr <= con_out[25:16];
                        count     <= con_out[11:0];
                        byte_idx  <= 12'd0;
                        busy      <= 1'b1;
                        if (con_out[11:0] == 12'd0) begin
                            state <= WB;
                        end else begin
                            state <= FETCH;
                        end
                    end else begin
                        state <= IDLE;
                    end
                end
                FETCH: begin
                    word_addr <= word_addr + 10'd1;
                    state     <= FETCH_WAIT;
                end
                FETCH_WAIT: begin
                    wbuf  <= con_out;
                    shreg <= pick(con_out, byte_idx[1:0]);
                    tx    <= 1'b0;
                    baud  <= '0;
                    state <= START;
                end
                START: begin
                    if (baud == BAUD_LAST) begin
                        baud    <= '0;
                        bit_cnt <= 3'd0;
                        tx      <= shreg[0];
                        state   <= DATA;
                    end else begin
                        baud <= baud + 1'b1;
                    end
                end
                DATA: begin
                    if (baud == BAUD_LAST) begin
                        baud <= '0;
                        if (bit_cnt == 3'd7) begin
                            tx    <= 1'b1;
                            state <= STOP;
                        end else begin
                            bit_cnt <= bit_cnt + 3'd1;
                            tx      <= shreg[1];
                            shreg   <= shreg >> 1;
                        end
                    end else begin
                        baud <= baud + 1'b1;
                    end
                end
                STOP: begin
                    if (baud == BAUD_LAST) begin
                        baud     <= '0;
                        byte_idx <= next_idx;
                        if (next_idx == count) begin
                            state <= WB;
                        end else if (next_idx[1:0] == 2'd0) begin
                            state <= FETCH;
                        end else begin
                            shreg <= pick(wbuf, next_idx[1:0]);
                            tx    <= 1'b0;
                            state <= START;
                        end
                    end else begin
                        baud <= baud + 1'b1;
                    end
                end
                WB: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    tx    <= 1'b1;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_con_uart_tx.sv
// Bench for con_uart_tx: datamem model plus a frame-level
// reference built from the mailbox contents.
module tb_con_uart_tx;

    localparam int CPB = 4;
    localparam logic [9:0] CMD = 10'h200;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] con_out;
    logic [9:0]  con_addr;
    logic [3:0]  con_write;
    logic [31:0] con_in;
    logic        tx;
    logic        busy;

    logic [31:0] mem [0:1023];
    logic [31:0] shadow [0:1023];
    logic        pk_we = 1'b0;
    logic [9:0]  pk_addr = 10'd0;
    logic [31:0] pk_data = 32'd0;
    int          n_wr = 0;
    int          n_cmp = 0;
    int          n_err = 0;

    con_uart_tx #(.CLKS_PER_BIT(CPB), .CMD_ADDR(CMD)) dut (
        .clk(clk),
        .rst(rst),
        .con_out(con_out),
        .con_addr(con_addr),
        .con_write(con_write),
        .con_in(con_in),
        .tx(tx),
        .busy(busy)
    );

    always #5 clk = ~clk;

    // Synchronous datamem: one-clock read latency, byte writes.
    always @(posedge clk) begin
        if (pk_we) mem[pk_addr] <= pk_data;
        for (int b = 0; b < 4; b++)
            if (con_write[b]) mem[con_addr][8*b +: 8] <= con_in[8*b +: 8];
        if (con_write != 4'b0000) n_wr <= n_wr + 1;
        con_out <= mem[con_addr];
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic poke(input logic [9:0] a, input logic [31:0] d);
        @(negedge clk);
        pk_we = 1'b1;
        pk_addr = a;
        pk_data = d;
        shadow[a] = d;
        @(negedge clk);
        pk_we = 1'b0;
    endtask

    task automatic hold_rst(input int n, input string tag);
        @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            chk({tag, "_tx"}, tx, 1);
            chk({tag, "_busy"}, busy, 0);
            chk({tag, "_we"}, con_write, 0);
            chk({tag, "_addr"}, con_addr, CMD);
            chk({tag, "_din"}, con_in, 0);
        end
    endtask

    task automatic release_rst();
        @(negedge clk);
        rst = 1'b0;
    endtask

    function automatic int stream(input logic [9:0] base, input int cnt,
                                  output logic q[$]);
        q = {};
        for (int k = 0; k < cnt; k++) begin
            int wa;
            int bv;
            wa = (int'(base) + k / 4) % 1024;
            bv = int'((shadow[wa] >> (8 * (k % 4))) & 32'hFF);
            repeat (CPB) q.push_back(1'b0);
            for (int i = 0; i < 8; i++)
                repeat (CPB) q.push_back(1'((bv >> i) & 1));
            repeat (CPB) q.push_back(1'b1);
            if ((k + 1) % 4 == 0 && k + 1 < cnt) begin
                q.push_back(1'b1);
                q.push_back(1'b1);
            end
        end
        return q.size();
    endfunction

    task automatic wait_start(input string tag);
        int t;
        t = 0;
        while (tx !== 1'b0 && t < 300) begin
            @(negedge clk);
            t++;
        end
        chk({tag, "_start"}, tx, 0);
        chk({tag, "_busy_hi"}, busy, 1);
    endtask

    task automatic finish_msg(input logic [9:0] base, input int cnt,
                              input int w0, input string tag);
        int t;
        logic [31:0] st;
        t = 0;
        while (busy !== 1'b0 && t < 8) begin
            @(negedge clk);
            t++;
        end
        chk({tag, "_busy_lo"}, busy, 0);
        st = 32'h4000_0000 + (32'(base) << 16) + 32'(cnt);
        chk({tag, "_status"}, mem[CMD], st);
        chk({tag, "_nwrites"}, n_wr - w0, 1);
        shadow[CMD] = st;
    endtask

    task automatic run_msg(input logic [9:0] base, input int cnt,
                           input string tag);
        logic q[$];
        int n;
        int w0;
        w0 = n_wr;
        n = stream(base, cnt, q);
        wait_start(tag);
        for (int i = 0; i < n; i++) begin
            if (i > 0) @(negedge clk);
            chk({tag, "_tx"}, tx, q[i]);
        end
        finish_msg(base, cnt, w0, tag);
    endtask

    initial begin
        logic q[$];
        int n;
        int w0;
        int lows;
        int his;
        int t;

        for (int i = 0; i < 1024; i++) begin
            mem[i] = 32'd0;
            shadow[i] = 32'd0;
        end

        // Reset behaviour and basic three-byte message
        hold_rst(3, "rst");
        poke(10'h001, 32'h4433_2211);
        poke(CMD, 32'h8001_0003);
        release_rst();
        run_msg(10'h001, 3, "basic");

        // Zero-length command
        hold_rst(1, "rst0");
        poke(CMD, 32'h8005_0000);
        release_rst();
        w0 = n_wr;
        lows = 0;
        t = 0;
        while (mem[CMD] !== 32'h4005_0000 && t < 12) begin
            @(negedge clk);
            if (tx !== 1'b1) lows++;
            t++;
        end
        chk("zero_status", mem[CMD], 32'h4005_0000);
        chk("zero_late", 32'(t > 5), 0);
        repeat (10) begin
            @(negedge clk);
            if (tx !== 1'b1) lows++;
        end
        chk("zero_notx", lows, 0);
        chk("zero_nwrites", n_wr - w0, 1);

        // Address wrap with idle gap before the fifth byte
        hold_rst(1, "rst1");
        poke(10'h3FF, 32'hDDCC_BBAA);
        poke(10'h000, 32'h0000_00EE);
        poke(CMD, 32'h83FF_0005);
        release_rst();
        run_msg(10'h3FF, 5, "wrap");

        // Reset during the fourth data bit aborts; then full resend
        hold_rst(1, "rst2");
        poke(10'h001, 32'h4433_2211);
        poke(CMD, 32'h8001_0003);
        release_rst();
        w0 = n_wr;
        n = stream(10'h001, 3, q);
        wait_start("abort");
        for (int i = 0; i <= 4 * CPB + 1; i++) begin
            if (i > 0) @(negedge clk);
            chk("abort_tx", tx, q[i]);
        end
        rst = 1'b1;
        @(negedge clk);
        chk("abort_tx_hi", tx, 1);
        chk("abort_busy", busy, 0);
        hold_rst(2, "abort_rst");
        chk("abort_nowrite", n_wr - w0, 0);
        chk("abort_keep_go", mem[CMD], 32'h8001_0003);
        release_rst();
        run_msg(10'h001, 3, "resend");

        // Randomized messages, junk in ignored command bits
        for (int r = 0; r < 6; r++) begin
            logic [9:0] base;
            int cnt;
            logic [31:0] cmd;
            base = 10'($urandom_range(0, 1023));
            cnt = $urandom_range(1, 9);
            hold_rst(1, "rstr");
            for (int k = 0; k < (cnt + 3) / 4; k++)
                poke(10'((int'(base) + k) % 1024), $urandom);
            cmd = 32'h8000_0000 | (32'(base) << 16) | 32'(cnt);
            cmd = cmd | (32'($urandom) & 32'h7C00_F000);
            poke(CMD, cmd);
            release_rst();
            run_msg(base, cnt, "rand");
        end

        // GO clear: keep polling, never transmit or write
        hold_rst(1, "rst3");
        poke(CMD, 32'h0001_0003);
        release_rst();
        w0 = n_wr;
        lows = 0;
        his = 0;
        repeat (200) begin
            @(negedge clk);
            if (tx !== 1'b1) lows++;
            if (busy !== 1'b0) his++;
        end
        chk("idle_notx", lows, 0);
        chk("idle_nobusy", his, 0);
        chk("idle_nowrite", n_wr - w0, 0);
        chk("idle_mbox", mem[CMD], 32'h0001_0003);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_err);
        $finish;
    end

endmodule
